gray_ptr_ctl: RTL and testbench
===============================

GRAY_PTR_CTL -- requirements
Module: gray_ptr_ctl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; FIFO depth is 2**ADDR_W; legal range 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on the remote pointer; legal range 2..4.
REQ-003 SHALL have parameter IS_WR, default 1; 1 = write-side controller (flag is full), 0 = read-side controller (flag is empty).
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port inc, input, 1, advance request (push if IS_WR=1, pop if IS_WR=0).
REQ-007 SHALL have port rem_gray_i, input, ADDR_W+1, Gray-coded pointer from the other clock domain; asynchronous to clk.
REQ-008 SHALL have port ptr_bin_o, output, ADDR_W+1, local binary pointer, registered.
REQ-009 SHALL have port ptr_gray_o, output, ADDR_W+1, local Gray pointer, registered directly from a flop with no logic after it.
REQ-010 SHALL have port addr_o, output, ADDR_W, RAM address, equal to ptr_bin_o[ADDR_W-1:0].
REQ-011 SHALL have port flag_o, output, 1, full (IS_WR=1) or empty (IS_WR=0), registered.
REQ-012 SHALL have port level_o, output, ADDR_W+1, occupancy as seen from this domain, registered, range 0..2**ADDR_W.

Function
REQ-013 SHALL pass rem_gray_i through SYNC_STAGES flops in series (rem_sync), with no logic between stages.
REQ-014 SHALL decode rem_sync to binary (rem_bin): bit MSB copied; each lower bit = XOR of all higher Gray bits and itself.
REQ-015 SHALL accept an advance only when accept = inc AND NOT flag_o; inc while flag_o=1 is ignored with no state change.
REQ-016 SHALL compute bin_next = ptr_bin_o + accept, modulo 2**(ADDR_W+1), wrapping from all-ones to 0.
REQ-017 SHALL compute gray_next = bin_next XOR (bin_next >> 1) and register both pointers every cycle.
REQ-018 SHALL, for IS_WR=1, register flag_o = (gray_next == {~rem_sync[ADDR_W:ADDR_W-1], rem_sync[ADDR_W-2:0]}); for ADDR_W=1 the inverted field is the full 2-bit pointer.
REQ-019 SHALL, for IS_WR=0, register flag_o = (gray_next == rem_sync).
REQ-020 SHALL register level_o = bin_next - rem_bin (IS_WR=1) or rem_bin - bin_next (IS_WR=0), modulo 2**(ADDR_W+1).
REQ-021 SHALL change at most one bit of ptr_gray_o per clock, including on wrap.
REQ-022 SHALL update flag_o in the same cycle as the accepted advance that fills or empties (no extra cycle of lag).
REQ-023 SHALL reflect a stable change of rem_gray_i in flag_o and level_o exactly SYNC_STAGES+1 clocks after the capturing edge.
REQ-024 SHALL, when accept and a remote-pointer change land in the same cycle, evaluate flag_o and level_o with both the new local pointer and the new rem_sync.

Reset
REQ-025 SHALL, while rst=1, force ptr_bin_o=0, ptr_gray_o=0, level_o=0, all synchroniser stages=0, with no clock required.
REQ-026 SHALL reset flag_o to 0 when IS_WR=1 and to 1 when IS_WR=0.
REQ-027 SHALL, on rst asserted mid-operation, discard any in-flight accept; first accept is possible on the first edge after rst deasserts.

Verification
REQ-028 SHALL verify write fill (ADDR_W=2, IS_WR=1, rem=0): four inc pulses -> ptr_gray_o 1,3,2,6; flag_o=1 with the 4th update; level_o=4; 5th inc leaves ptr_bin_o=4.
REQ-029 SHALL verify full release: from fill state, set rem_gray_i=1 -> flag_o=0 and level_o=3 exactly SYNC_STAGES+1 clocks later.
REQ-030 SHALL verify wrap: with the remote pointer tracking, 8 accepts -> ptr_gray_o sequence 1,3,2,6,7,5,4,0; one bit changes per step.
REQ-031 SHALL verify read mode (ADDR_W=2, IS_WR=0): after reset flag_o=1; rem_gray_i=2 (binary 3) -> after SYNC_STAGES+1 clocks flag_o=0, level_o=3; three pops -> flag_o=1 on the 3rd.
REQ-032 SHALL verify simultaneous events: pop of the last entry in the same cycle the new remote pointer arrives -> flag_o stays 0 and level_o reflects both.
REQ-033 SHALL verify async reset mid-burst: rst asserted between edges -> all outputs return to reset values immediately; inc on that edge ignored.

Source files
------------

// File: rtl/gray_ptr_ctl.sv
// Gray-coded pointer controller for one side of an async FIFO.
// Synchronises the remote Gray pointer and produces full/empty and occupancy.
module gray_ptr_ctl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IS_WR       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [ADDR_W:0]   rem_gray_i,
  output logic [ADDR_W:0]   ptr_bin_o,
  output logic [ADDR_W:0]   ptr_gray_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              flag_o,
  output logic [ADDR_W:0]   level_o
);

  // Top two Gray bits inverted marks the write pointer one lap ahead of the read pointer.
  localparam logic [ADDR_W:0] FULL_MASK = (ADDR_W+1)'(3) << (ADDR_W - 1);
  localparam logic            FLAG_RST  = (IS_WR != 0) ? 1'b0 : 1'b1;

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rem_sync;
  logic [ADDR_W:0] rem_bin;

  logic [ADDR_W:0] ptr_bin_q, ptr_gray_q, level_q;
  logic [ADDR_W:0] bin_next, gray_next, level_d;
  logic            flag_q, flag_d;
  logic            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rem_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rem_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    rem_bin         = '0;
    rem_bin[ADDR_W] = rem_sync[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) rem_bin[i] = rem_bin[i+1] ^ rem_sync[i];
  end

  always_comb begin
    accept    = inc & ~flag_q;
    bin_next  = ptr_bin_q + {{ADDR_W{1'b0}}, accept};
    gray_next = bin_next ^ (bin_next >> 1);
    flag_d    = FLAG_RST;
    level_d   = '0;
    if (IS_WR != 0) begin
      flag_d  = (gray_next == (rem_sync ^ FULL_MASK));
      level_d = bin_next - rem_bin;
    end else begin
      flag_d  = (gray_next == rem_sync);
      level_d = rem_bin - bin_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      flag_q     <= FLAG_RST;
      level_q    <= '0;
    end else begin
      ptr_bin_q  <= bin_next;
      ptr_gray_q <= gray_next;
      flag_q     <= flag_d;
      level_q    <= level_d;
    end
  end

  assign ptr_bin_o  = ptr_bin_q;
  assign ptr_gray_o = ptr_gray_q;
  assign addr_o     = ptr_bin_q[ADDR_W-1:0];
  assign flag_o     = flag_q;
  assign level_o    = level_q;

endmodule

// File: tb/tb_gray_ptr_ctl.sv
// Directed bench: write-side and read-side controllers (ADDR_W=2, SYNC_STAGES=2).
module tb_gray_ptr_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w_inc, r_inc;
  logic [2:0] w_rem, r_rem;
  logic [2:0] w_bin, w_gray, w_level, r_bin, r_gray, r_level;
  logic [1:0] w_addr, r_addr;
  logic       w_flag, r_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_ptr_ctl #(.ADDR_W(2), .SYNC_STAGES(2), .IS_WR(1)) u_wr (
    .clk(clk), .rst(rst), .inc(w_inc), .rem_gray_i(w_rem),
    .ptr_bin_o(w_bin), .ptr_gray_o(w_gray), .addr_o(w_addr),
    .flag_o(w_flag), .level_o(w_level)
  );

  gray_ptr_ctl #(.ADDR_W(2), .SYNC_STAGES(2), .IS_WR(0)) u_rd (
    .clk(clk), .rst(rst), .inc(r_inc), .rem_gray_i(r_rem),
    .ptr_bin_o(r_bin), .ptr_gray_o(r_gray), .addr_o(r_addr),
    .flag_o(r_flag), .level_o(r_level)
  );

  typedef struct {
    logic       rd;
    logic       inc;
    logic [2:0] rem;
    logic [2:0] bin;
    logic [2:0] gray;
    logic       flag;
    logic [2:0] level;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_side(input string tag, input logic rd, input logic [2:0] bin,
                          input logic [2:0] gray, input logic flag, input logic [2:0] level);
    if (rd) begin
      chk({tag, " bin"}, int'(r_bin), int'(bin));
      chk({tag, " gray"}, int'(r_gray), int'(gray));
      chk({tag, " addr"}, int'(r_addr), int'(bin[1:0]));
      chk({tag, " flag"}, int'(r_flag), int'(flag));
      chk({tag, " level"}, int'(r_level), int'(level));
    end else begin
      chk({tag, " bin"}, int'(w_bin), int'(bin));
      chk({tag, " gray"}, int'(w_gray), int'(gray));
      chk({tag, " addr"}, int'(w_addr), int'(bin[1:0]));
      chk({tag, " flag"}, int'(w_flag), int'(flag));
      chk({tag, " level"}, int'(w_level), int'(level));
    end
  endtask

  logic [2:0] wrap_exp [8];
  logic [2:0] prev_gray;

  initial begin
    // rd inc rem bin gray flag level
    vecs = '{
      // write fill, blocked 5th push, release after sync latency
      '{1'b0, 1'b1, 3'd0, 3'd1, 3'd1, 1'b0, 3'd1},
      '{1'b0, 1'b1, 3'd0, 3'd2, 3'd3, 1'b0, 3'd2},
      '{1'b0, 1'b1, 3'd0, 3'd3, 3'd2, 1'b0, 3'd3},
      '{1'b0, 1'b1, 3'd0, 3'd4, 3'd6, 1'b1, 3'd4},
      '{1'b0, 1'b1, 3'd0, 3'd4, 3'd6, 1'b1, 3'd4},
      '{1'b0, 1'b0, 3'd1, 3'd4, 3'd6, 1'b1, 3'd4},
      '{1'b0, 1'b0, 3'd1, 3'd4, 3'd6, 1'b1, 3'd4},
      '{1'b0, 1'b0, 3'd1, 3'd4, 3'd6, 1'b0, 3'd3},
      '{1'b0, 1'b1, 3'd1, 3'd5, 3'd7, 1'b1, 3'd4},
      // read side: remote fills to 3, three pops empty it
      '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 3'd0},
      '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 3'd0},
      '{1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 3'd3},
      '{1'b1, 1'b1, 3'd2, 3'd1, 3'd1, 1'b0, 3'd2},
      '{1'b1, 1'b1, 3'd2, 3'd2, 3'd3, 1'b0, 3'd1},
      '{1'b1, 1'b1, 3'd2, 3'd3, 3'd2, 1'b1, 3'd0},
      '{1'b1, 1'b1, 3'd2, 3'd3, 3'd2, 1'b1, 3'd0},
      // remote to 4, then to 5 landing with the pop of the last entry
      '{1'b1, 1'b0, 3'd6, 3'd3, 3'd2, 1'b1, 3'd0},
      '{1'b1, 1'b0, 3'd6, 3'd3, 3'd2, 1'b1, 3'd0},
      '{1'b1, 1'b0, 3'd6, 3'd3, 3'd2, 1'b0, 3'd1},
      '{1'b1, 1'b0, 3'd7, 3'd3, 3'd2, 1'b0, 3'd1},
      '{1'b1, 1'b0, 3'd7, 3'd3, 3'd2, 1'b0, 3'd1},
      '{1'b1, 1'b1, 3'd7, 3'd4, 3'd6, 1'b0, 3'd1}
    };
    wrap_exp = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};

    w_inc = 1'b0; r_inc = 1'b0; w_rem = '0; r_rem = '0;
    #1 rst = 1'b1;
    #1;
    chk_side("reset wr", 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_side("reset rd", 1'b1, 3'd0, 3'd0, 1'b1, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (vecs[i].rd) begin
        w_inc = 1'b0;
        r_inc = vecs[i].inc;
        r_rem = vecs[i].rem;
      end else begin
        r_inc = 1'b0;
        w_inc = vecs[i].inc;
        w_rem = vecs[i].rem;
      end
      step();
      chk_side($sformatf("vec%0d", i), vecs[i].rd, vecs[i].bin, vecs[i].gray,
               vecs[i].flag, vecs[i].level);
    end

    // Wrap with the remote pointer trailing the local one
    @(negedge clk);
    w_inc = 1'b0; r_inc = 1'b0; w_rem = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev_gray = 3'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w_inc = 1'b1;
      w_rem = prev_gray;
      step();
      chk($sformatf("wrap gray %0d", k), int'(w_gray), int'(wrap_exp[k]));
      chk($sformatf("wrap onebit %0d", k), $countones(w_gray ^ prev_gray), 1);
      chk($sformatf("wrap flag %0d", k), int'(w_flag), 0);
      prev_gray = wrap_exp[k];
    end
    chk("wrap bin", int'(w_bin), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_rem = prev_gray;
      step();
      prev_gray = wrap_exp[k];
    end
    chk("burst bin", int'(w_bin), 2);

    // Async reset between edges with inc held high
    @(negedge clk);
    w_inc = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_side("async rst wr", 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
    chk_side("async rst rd", 1'b1, 3'd0, 3'd0, 1'b1, 3'd0);
    step();
    chk("rst edge bin", int'(w_bin), 0);
    chk("rst edge gray", int'(w_gray), 0);
    @(negedge clk);
    rst = 1'b0;
    w_rem = 3'd0;
    step();
    chk("post rst bin", int'(w_bin), 1);
    chk("post rst gray", int'(w_gray), 1);
    w_inc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
